seg7_scan_ctrl: RTL

//  Time-multiplexed scan controller for an NDIG-digit common-anode 7-segment display.

---
 rtl/seg7_scan_ctrl.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed NDIG-digit 7-segment scan controller with a prescaler tick, a blank slot between digits and a double-buffered value.
// Optional build macro LEADING_ZERO_BLANK_EN keeps leading-zero digits dark.
module seg7_scan_ctrl #(
  parameter int unsigned DIV_BITS   = 17,
  parameter int unsigned NDIG       = 4,
  parameter int unsigned SHOW_TICKS = 3
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              load,
  input  logic [4*NDIG-1:0] bcd_in,
  input  logic [NDIG-1:0]   dp_in,
  output logic [NDIG-1:0]   an,
  output logic [6:0]        seg,
  output logic              dp,
  output logic              frame_done
);

  localparam int unsigned IW = $clog2(NDIG);

  // ST_INIT is the post-reset blank slot; unlike ST_BLANK it leads to digit 0 without ending a frame.
  typedef enum logic [1:0] {ST_INIT, ST_SHOW, ST_BLANK} state_e;

  state_e              state_q, state_d;
  logic [DIV_BITS-1:0] presc_q;
  logic [IW-1:0]       idx_q, idx_d;
  logic [3:0]          tcnt_q, tcnt_d;
  logic [4*NDIG-1:0]   sh_bcd_q, sh_bcd_d, act_bcd_q, act_bcd_d;
  logic [NDIG-1:0]     sh_dp_q, sh_dp_d, act_dp_q, act_dp_d;
  logic                pend_q, pend_d;
  logic [NDIG-1:0]     an_q, an_d;
  logic [6:0]          seg_q, seg_d;
  logic                dp_q, dp_d;
  logic                fd_q, fd_d;
  logic                tick, wrap;

  assign tick = &presc_q;

  function automatic logic [6:0] dec7(input logic [3:0] v);
    case (v)
      4'd0:    dec7 = 7'h40;
      4'd1:    dec7 = 7'h79;
      4'd2:    dec7 = 7'h24;
      4'd3:    dec7 = 7'h30;
      4'd4:    dec7 = 7'h19;
      4'd5:    dec7 = 7'h12;
      4'd6:    dec7 = 7'h02;
      4'd7:    dec7 = 7'h78;
      4'd8:    dec7 = 7'h00;
      4'd9:    dec7 = 7'h10;
      default: dec7 = 7'h3F;
    endcase
  endfunction

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    tcnt_d  = tcnt_q;
    wrap    = 1'b0;
    fd_d    = 1'b0;
    if (tick) begin
      case (state_q)
        ST_INIT: begin
          state_d = ST_SHOW;
          idx_d   = '0;
          tcnt_d  = '0;
        end
        ST_SHOW: begin
          if (tcnt_q == 4'(SHOW_TICKS - 1)) begin
            state_d = ST_BLANK;
            tcnt_d  = '0;
          end else begin
            tcnt_d = tcnt_q + 4'd1;
          end
        end
        default: begin
          state_d = ST_SHOW;
          if (idx_q == IW'(NDIG - 1)) begin
            idx_d = '0;
            wrap  = 1'b1;
            fd_d  = 1'b1;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      endcase
    end
  end

  // A load on the wrap edge or in the frame_done cycle bypasses the shadow so the new frame shows it at once.
  always_comb begin
    sh_bcd_d  = sh_bcd_q;
    sh_dp_d   = sh_dp_q;
    act_bcd_d = act_bcd_q;
    act_dp_d  = act_dp_q;
    pend_d    = pend_q;
    if (wrap && pend_q) begin
      act_bcd_d = sh_bcd_q;
      act_dp_d  = sh_dp_q;
      pend_d    = 1'b0;
    end
    if (load) begin
      sh_bcd_d = bcd_in;
      sh_dp_d  = dp_in;
      if (wrap || fd_q) begin
        act_bcd_d = bcd_in;
        act_dp_d  = dp_in;
        pend_d    = 1'b0;
      end else begin
        pend_d = 1'b1;
      end
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  logic [NDIG-1:0] lz;

  always_comb begin
    lz = '0;
    lz[NDIG-1] = (act_bcd_d[4*NDIG-1 -: 4] == 4'd0);
    for (int unsigned k = 1; k < NDIG; k++) begin
      lz[NDIG-1-k] = lz[NDIG-k] & (act_bcd_d[4*(NDIG-1-k) +: 4] == 4'd0);
    end
  end
`endif

  always_comb begin
    an_d  = '1;
    seg_d = 7'h7F;
    dp_d  = 1'b1;
    if (state_d == ST_SHOW) begin
      seg_d        = dec7(act_bcd_d[{idx_d, 2'b00} +: 4]);
      dp_d         = ~act_dp_d[idx_d];
      an_d[idx_d]  = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
      if ((idx_d != '0) && lz[idx_d] && !act_dp_d[idx_d]) an_d = '1;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      presc_q   <= '0;
      state_q   <= ST_INIT;
      idx_q     <= '0;
      tcnt_q    <= '0;
      sh_bcd_q  <= '0;
      sh_dp_q   <= '0;
      act_bcd_q <= '0;
      act_dp_q  <= '0;
      pend_q    <= 1'b0;
      an_q      <= '1;
      seg_q     <= 7'h7F;
      dp_q      <= 1'b1;
      fd_q      <= 1'b0;
    end else begin
      presc_q   <= presc_q + 1'b1;
      state_q   <= state_d;
      idx_q     <= idx_d;
      tcnt_q    <= tcnt_d;
      sh_bcd_q  <= sh_bcd_d;
      sh_dp_q   <= sh_dp_d;
      act_bcd_q <= act_bcd_d;
      act_dp_q  <= act_dp_d;
      pend_q    <= pend_d;
      an_q      <= an_d;
      seg_q     <= seg_d;
      dp_q      <= dp_d;
      fd_q      <= fd_d;
    end
  end

  assign an         = an_q;
  assign seg        = seg_q;
  assign dp         = dp_q;
  assign frame_done = fd_q;

endmodule
